axi_sram_slave: RTL and testbench

//  AXI4 responder that sits behind the interconnect's per-slave arbiter and serves one granted master at a time.

---
 rtl/axi_sram_slave.sv | 182 ++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// AXI4 slave serving one burst at a time from a single-port synchronous SRAM.
// AR/AW contention alternates priority; read data is 1 beat/cycle when RREADY stays high.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for AR or AW; priority bit picks the winner on contention
// RD_ISSUE | first SRAM read issued for the burst
// RD_DATA  | R beat presented; a handshake issues the next read in the same cycle
// WR_DATA  | accepting W beats, one SRAM write per beat
// WR_RESP  | B response presented until BREADY
module axi_sram_slave #(
   parameter int IDW   = 8,
   parameter int MEMAW = 14
) (
   input  logic             ACLK,
   input  logic             ARESETn,
   input  logic [IDW-1:0]   ARID,
   input  logic [31:0]      ARADDR,
   input  logic [3:0]       ARLEN,
   input  logic [1:0]       ARBURST,
   input  logic             ARVALID,
   output logic             ARREADY,
   output logic [IDW-1:0]   RID,
   output logic [31:0]      RDATA,
   output logic [1:0]       RRESP,
   output logic             RLAST,
   output logic             RVALID,
   input  logic             RREADY,
   input  logic [IDW-1:0]   AWID,
   input  logic [31:0]      AWADDR,
   input  logic [3:0]       AWLEN,
   input  logic [1:0]       AWBURST,
   input  logic             AWVALID,
   output logic             AWREADY,
   input  logic [31:0]      WDATA,
   input  logic [3:0]       WSTRB,
   input  logic             WLAST,
   input  logic             WVALID,
   output logic             WREADY,
   output logic [IDW-1:0]   BID,
   output logic [1:0]       BRESP,
   output logic             BVALID,
   input  logic             BREADY,
   output logic             mem_cs,
   output logic [3:0]       mem_we,
   output logic [MEMAW-1:0] mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata
);

   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_DATA, WR_DATA, WR_RESP} state_t;

   state_t           state, state_nxt;
   logic             prio_wr;
   logic [IDW-1:0]   id_q;
   logic [MEMAW-1:0] addr_q, addr_next;
   logic [3:0]       len_q, cnt_q;
   logic             fixed_q;
   logic             err_q;
   logic             fresh_q;
   logic [31:0]      rdata_q;
   logic             last_beat;
   logic             unused_addr_bits;

   assign unused_addr_bits = ^{ARADDR[31:MEMAW+2], ARADDR[1:0], AWADDR[31:MEMAW+2], AWADDR[1:0]};

   assign ARREADY   = (state == IDLE) && ARVALID && (!AWVALID || !prio_wr);
   assign AWREADY   = (state == IDLE) && AWVALID && (!ARVALID || prio_wr);
   assign WREADY    = (state == WR_DATA);
   assign RVALID    = (state == RD_DATA);
   assign BVALID    = (state == WR_RESP);
   assign last_beat = (cnt_q == len_q);
   assign addr_next = fixed_q ? addr_q : addr_q + MEMAW'(1);

   // SRAM output is only valid the cycle after the read; afterwards the captured copy holds RDATA.
   assign RDATA = fresh_q ? mem_rdata : rdata_q;
   assign RID   = id_q;
   assign RLAST = RVALID && last_beat;
   assign RRESP = 2'b00;
   assign BID   = id_q;
   assign BRESP = err_q ? 2'b10 : 2'b00;

   always_comb begin
      state_nxt = state;
      mem_cs    = 1'b0;
      mem_we    = 4'b0000;
      mem_addr  = addr_q;
      mem_wdata = '0;
      case (state)
         IDLE: begin
            if (ARREADY)      state_nxt = RD_ISSUE;
            else if (AWREADY) state_nxt = WR_DATA;
         end
         RD_ISSUE: begin
            mem_cs    = 1'b1;
            state_nxt = RD_DATA;
         end
         RD_DATA: begin
            if (RREADY) begin
               if (last_beat) begin
                  state_nxt = IDLE;
               end else begin
                  mem_cs   = 1'b1;
                  mem_addr = addr_next;
               end
            end
         end
         WR_DATA: begin
            if (WVALID) begin
               mem_cs    = |WSTRB;
               mem_we    = WSTRB;
               mem_wdata = WDATA;
               if (WLAST || last_beat) state_nxt = WR_RESP;
            end
         end
         WR_RESP: begin
            if (BREADY) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state   <= IDLE;
         prio_wr <= 1'b0;
         id_q    <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         fixed_q <= 1'b0;
         err_q   <= 1'b0;
         fresh_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state   <= state_nxt;
         fresh_q <= 1'b0;
         if (fresh_q) rdata_q <= mem_rdata;
         case (state)
            IDLE: begin
               if (ARREADY) begin
                  id_q    <= ARID;
                  addr_q  <= ARADDR[MEMAW+1:2];
                  len_q   <= ARLEN;
                  fixed_q <= (ARBURST == 2'b00);
                  cnt_q   <= '0;
                  prio_wr <= 1'b1;
               end else if (AWREADY) begin
                  id_q    <= AWID;
                  addr_q  <= AWADDR[MEMAW+1:2];
                  len_q   <= AWLEN;
                  fixed_q <= (AWBURST == 2'b00);
                  cnt_q   <= '0;
                  prio_wr <= 1'b0;
               end
            end
            RD_ISSUE: fresh_q <= 1'b1;
            RD_DATA: begin
               if (RREADY && !last_beat) begin
                  fresh_q <= 1'b1;
                  addr_q  <= addr_next;
                  cnt_q   <= cnt_q + 4'd1;
               end
            end
            WR_DATA: begin
               if (WVALID) begin
                  err_q <= err_q | (WLAST ^ last_beat);
                  if (!(WLAST || last_beat)) begin
                     addr_q <= addr_next;
                     cnt_q  <= cnt_q + 4'd1;
                  end
               end
            end
            WR_RESP: begin
               if (BREADY) err_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: a reference memory predicts R beats and B responses,
// and a behavioural SRAM macro sits on the mem_* port.
module tb_axi_sram_slave;
   localparam int IDW   = 8;
   localparam int MEMAW = 14;

   logic             ACLK = 1'b0;
   logic             ARESETn;
   logic [IDW-1:0]   ARID, AWID, RID, BID;
   logic [31:0]      ARADDR, AWADDR, RDATA, WDATA;
   logic [3:0]       ARLEN, AWLEN, WSTRB;
   logic [1:0]       ARBURST, AWBURST, RRESP, BRESP;
   logic             ARVALID, ARREADY, RLAST, RVALID, RREADY;
   logic             AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic             mem_cs;
   logic [3:0]       mem_we;
   logic [MEMAW-1:0] mem_addr;
   logic [31:0]      mem_wdata, mem_rdata;

   always #5 ACLK = ~ACLK;

   axi_sram_slave #(.IDW(IDW), .MEMAW(MEMAW)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
      .RVALID(RVALID), .RREADY(RREADY),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   logic [31:0] sram [0:(1<<MEMAW)-1];
   always @(posedge ACLK) begin
      if (mem_cs) begin
         if (mem_we == 4'b0000) mem_rdata <= sram[mem_addr];
         else for (int k = 0; k < 4; k++) if (mem_we[k]) sram[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
   end

   typedef struct {logic [31:0] data; logic last; logic [IDW-1:0] id;} rexp_t;
   typedef struct {logic [IDW-1:0] id; logic [1:0] resp;} bexp_t;
   rexp_t rq[$];
   bexp_t bq[$];
   logic [31:0] ref_mem [0:(1<<MEMAW)-1];
   logic [31:0] wbuf [0:15];
   logic [3:0]  sbuf [0:15];
   int checks = 0;
   int errors = 0;
   logic model_prio_wr;
   logic [IDW-1:0]   w_id;
   logic [MEMAW-1:0] w_addr;
   logic [3:0]       w_len;
   logic             w_fixed;

   task automatic apply_reset();
      ARESETn = 1'b0;
      repeat (2) @(negedge ACLK);
      ARESETn = 1'b1;
      model_prio_wr = 1'b0;
   endtask

   task automatic send_ar(input logic [IDW-1:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] burst);
      int n = 0;
      logic [MEMAW-1:0] a;
      ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
      #1;
      while (!ARREADY && n < 100) begin @(negedge ACLK); #1; n++; end
      checks++;
      if (ARREADY !== 1'b1) begin errors++; $display("FAIL ar_accept ARREADY=%b required 1", ARREADY); end
      a = addr[MEMAW+1:2];
      for (int b = 0; b <= int'(len); b++) begin
         rq.push_back('{ref_mem[a], (b == int'(len)), id});
         if (burst != 2'b00) a = a + 1'b1;
      end
      model_prio_wr = 1'b1;
      @(negedge ACLK);
      ARVALID = 1'b0;
   endtask

   task automatic read_beats(input bit stall, input bit chk_lat, output int span);
      int c = 1, guard = 0, first = -1, last = -1;
      bit held_v = 0;
      logic [31:0] held = '0;
      rexp_t e;
      #1;
      while (!RVALID && c < 50) begin @(negedge ACLK); #1; c++; end
      if (chk_lat) begin
         checks++;
         if (c != 2) begin errors++; $display("FAIL rd_latency cycles=%0d required 2", c); end
      end
      while (rq.size() > 0 && guard < 300) begin
         RREADY = stall ? (guard % 2 == 1) : 1'b1;
         if (RVALID) begin
            if (held_v) begin
               checks++;
               if (RDATA !== held) begin errors++; $display("FAIL rd_stall_hold RDATA=%h required %h", RDATA, held); end
            end
            if (RREADY) begin
               e = rq.pop_front();
               checks++;
               if (RDATA !== e.data || RLAST !== e.last || RID !== e.id || RRESP !== 2'b00) begin
                  errors++;
                  $display("FAIL rd_beat got data=%h last=%b id=%h resp=%b required data=%h last=%b id=%h resp=00",
                           RDATA, RLAST, RID, RRESP, e.data, e.last, e.id);
               end
               if (first < 0) first = guard;
               last = guard;
               held_v = 0;
            end else begin
               held = RDATA;
               held_v = 1;
            end
         end
         @(negedge ACLK); #1; guard++;
      end
      RREADY = 1'b0;
      checks++;
      if (rq.size() != 0) begin errors++; $display("FAIL rd_timeout beats_left=%0d required 0", rq.size()); end
      rq.delete();
      checks++;
      if (RVALID !== 1'b0) begin errors++; $display("FAIL rd_end RVALID=%b required 0", RVALID); end
      span = last - first;
   endtask

   task automatic send_aw(input logic [IDW-1:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] burst);
      int n = 0;
      AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
      #1;
      while (!AWREADY && n < 100) begin @(negedge ACLK); #1; n++; end
      checks++;
      if (AWREADY !== 1'b1) begin errors++; $display("FAIL aw_accept AWREADY=%b required 1", AWREADY); end
      w_id = id; w_addr = addr[MEMAW+1:2]; w_len = len; w_fixed = (burst == 2'b00);
      model_prio_wr = 1'b0;
      @(negedge ACLK);
      AWVALID = 1'b0;
   endtask

   task automatic write_beats(input int wlast_idx, input int bready_delay);
      int nb;
      logic err;
      logic [MEMAW-1:0] a;
      bexp_t e;
      nb  = (wlast_idx < int'(w_len)) ? wlast_idx + 1 : int'(w_len) + 1;
      err = (wlast_idx != int'(w_len));
      a   = w_addr;
      bq.push_back('{w_id, err ? 2'b10 : 2'b00});
      for (int b = 0; b < nb; b++) begin
         WVALID = 1'b1; WDATA = wbuf[b]; WSTRB = sbuf[b]; WLAST = (b == wlast_idx);
         #1;
         checks++;
         if (WREADY !== 1'b1) begin errors++; $display("FAIL wr_ready beat=%0d WREADY=%b required 1", b, WREADY); end
         for (int k = 0; k < 4; k++) if (sbuf[b][k]) ref_mem[a][8*k +: 8] = wbuf[b][8*k +: 8];
         if (!w_fixed) a = a + 1'b1;
         @(negedge ACLK);
      end
      WVALID = 1'b0; WLAST = 1'b0;
      #1;
      checks++;
      if (BVALID !== 1'b1) begin errors++; $display("FAIL wr_b_latency BVALID=%b required 1", BVALID); end
      if (bready_delay > 0) begin
         repeat (bready_delay) begin @(negedge ACLK); #1; end
         checks++;
         if (BVALID !== 1'b1) begin errors++; $display("FAIL wr_b_hold BVALID=%b required 1", BVALID); end
      end
      BREADY = 1'b1;
      e = bq.pop_front();
      checks++;
      if (BID !== e.id || BRESP !== e.resp) begin
         errors++;
         $display("FAIL wr_resp BID=%h BRESP=%b required BID=%h BRESP=%b", BID, BRESP, e.id, e.resp);
      end
      @(negedge ACLK);
      BREADY = 1'b0;
      #1;
      checks++;
      if (BVALID !== 1'b0) begin errors++; $display("FAIL wr_b_clear BVALID=%b required 0", BVALID); end
   endtask

   task automatic test_reset();
      ARESETn = 1'b0;
      repeat (3) @(negedge ACLK);
      #1;
      checks++;
      if ({ARREADY, AWREADY, WREADY, RVALID, BVALID, RLAST, mem_cs} !== 7'b0 || mem_we !== 4'b0) begin
         errors++;
         $display("FAIL reset_ctrl ar=%b aw=%b w=%b rv=%b bv=%b rl=%b cs=%b we=%b required all 0",
                  ARREADY, AWREADY, WREADY, RVALID, BVALID, RLAST, mem_cs, mem_we);
      end
      checks++;
      if (RID !== '0 || RDATA !== '0 || BID !== '0 || RRESP !== 2'b00 || BRESP !== 2'b00) begin
         errors++;
         $display("FAIL reset_data RID=%h RDATA=%h BID=%h RRESP=%b BRESP=%b required zeros", RID, RDATA, BID, RRESP, BRESP);
      end
      @(negedge ACLK);
      ARESETn = 1'b1;
      model_prio_wr = 1'b0;
   endtask

   task automatic test_single();
      int span;
      wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
      send_aw(8'h11, 32'h10, 4'd0, 2'b01);
      write_beats(0, 0);
      send_ar(8'h22, 32'h10, 4'd0, 2'b01);
      read_beats(0, 1, span);
   endtask

   task automatic test_incr_burst();
      int span;
      for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA000_0000 + i * 32'h0101; sbuf[i] = 4'hF; end
      send_aw(8'h31, 32'h10, 4'd3, 2'b01);
      write_beats(3, 2);
      send_ar(8'h32, 32'h10, 4'd3, 2'b01);
      read_beats(0, 1, span);
      checks++;
      if (span != 3) begin errors++; $display("FAIL rd_back_to_back span=%0d required 3", span); end
      send_ar(8'h33, 32'h10, 4'd3, 2'b01);
      read_beats(1, 1, span);
   endtask

   task automatic test_contention();
      int span;
      apply_reset();
      wbuf[0] = 32'h0BADCAFE; sbuf[0] = 4'hF;
      AWID = 8'h41; AWADDR = 32'h200; AWLEN = 4'd0; AWBURST = 2'b01; AWVALID = 1'b1;
      ARID = 8'h42; ARADDR = 32'h10; ARLEN = 4'd1; ARBURST = 2'b01; ARVALID = 1'b1;
      #1;
      checks++;
      if (ARREADY !== !model_prio_wr || AWREADY !== model_prio_wr) begin
         errors++; $display("FAIL arb_first ARREADY=%b AWREADY=%b required %b %b", ARREADY, AWREADY, !model_prio_wr, model_prio_wr);
      end
      send_ar(8'h42, 32'h10, 4'd1, 2'b01);
      #1;
      checks++;
      if (AWREADY !== 1'b0) begin errors++; $display("FAIL arb_busy AWREADY=%b required 0", AWREADY); end
      read_beats(0, 1, span);
      ARID = 8'h43; ARADDR = 32'h200; ARLEN = 4'd0; ARBURST = 2'b01; ARVALID = 1'b1;
      #1;
      checks++;
      if (ARREADY !== !model_prio_wr || AWREADY !== model_prio_wr) begin
         errors++; $display("FAIL arb_second ARREADY=%b AWREADY=%b required %b %b", ARREADY, AWREADY, !model_prio_wr, model_prio_wr);
      end
      send_aw(8'h41, 32'h200, 4'd0, 2'b01);
      #1;
      checks++;
      if (ARREADY !== 1'b0) begin errors++; $display("FAIL arb_wr_busy ARREADY=%b required 0", ARREADY); end
      write_beats(0, 1);
      send_ar(8'h43, 32'h200, 4'd0, 2'b01);
      read_beats(0, 1, span);
   endtask

   task automatic test_partial();
      int span;
      wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF;
      send_aw(8'h51, 32'h40, 4'd0, 2'b01);
      write_beats(0, 0);
      wbuf[0] = 32'h12345678; sbuf[0] = 4'b0011;
      send_aw(8'h52, 32'h40, 4'd0, 2'b01);
      write_beats(0, 0);
      send_ar(8'h53, 32'h40, 4'd0, 2'b01);
      read_beats(0, 0, span);
      wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222; wbuf[2] = 32'h33333333;
      sbuf[0] = 4'hF; sbuf[1] = 4'hF; sbuf[2] = 4'hF;
      send_aw(8'h54, 32'h80, 4'd2, 2'b00);
      write_beats(2, 0);
      send_ar(8'h55, 32'h80, 4'd1, 2'b01);
      read_beats(0, 0, span);
      wbuf[0] = 32'hCAFEF00D; wbuf[1] = 32'hBAD0BAD0; sbuf[0] = 4'hF; sbuf[1] = 4'h0;
      send_aw(8'h56, 32'h90, 4'd1, 2'b01);
      write_beats(1, 0);
      send_ar(8'h57, 32'h90, 4'd1, 2'b01);
      read_beats(0, 0, span);
      send_ar(8'h58, 32'h80, 4'd2, 2'b00);
      read_beats(1, 0, span);
   endtask

   task automatic test_wlast_err();
      int span;
      for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h5A5A_0000 + i; sbuf[i] = 4'hF; end
      send_aw(8'h5A, 32'h100, 4'd3, 2'b01);
      write_beats(1, 1);
      wbuf[0] = 32'h600DF00D; sbuf[0] = 4'hF;
      send_aw(8'h5B, 32'h10C, 4'd0, 2'b01);
      write_beats(0, 0);
      send_ar(8'h5C, 32'h100, 4'd3, 2'b01);
      read_beats(0, 0, span);
   endtask

   task automatic test_wrap_len15();
      int span;
      for (int i = 0; i < 16; i++) begin wbuf[i] = 32'h7700_0000 + i * 32'h11; sbuf[i] = 4'hF; end
      send_aw(8'h61, 32'hFFE0, 4'd15, 2'b01);
      write_beats(15, 0);
      send_ar(8'h62, 32'hFFE0, 4'd15, 2'b11);
      read_beats(0, 1, span);
      checks++;
      if (span != 15) begin errors++; $display("FAIL rd_len15_span span=%0d required 15", span); end
   endtask

   task automatic test_reset_mid();
      int n = 0, span;
      bit seen = 0;
      send_ar(8'h71, 32'h10, 4'd3, 2'b01);
      #1;
      while (!RVALID && n < 50) begin @(negedge ACLK); #1; n++; end
      RREADY = 1'b1;
      @(negedge ACLK); #1;
      checks++;
      if (RVALID !== 1'b1) begin errors++; $display("FAIL rst_mid_beat2 RVALID=%b required 1", RVALID); end
      ARESETn = 1'b0;
      @(negedge ACLK); #1;
      checks++;
      if (RVALID !== 1'b0 || RDATA !== '0 || RID !== '0 || mem_cs !== 1'b0) begin
         errors++; $display("FAIL rst_mid_abort RVALID=%b RDATA=%h RID=%h mem_cs=%b required 0", RVALID, RDATA, RID, mem_cs);
      end
      RREADY = 1'b0;
      ARESETn = 1'b1;
      model_prio_wr = 1'b0;
      rq.delete();
      repeat (4) begin @(negedge ACLK); #1; if (RVALID || BVALID) seen = 1; end
      checks++;
      if (seen) begin errors++; $display("FAIL rst_mid_no_resp seen=%b required 0", seen); end
      send_ar(8'h72, 32'h10, 4'd0, 2'b01);
      read_beats(0, 1, span);
   endtask

   initial begin
      for (int i = 0; i < (1 << MEMAW); i++) begin sram[i] = '0; ref_mem[i] = '0; end
      mem_rdata = '0;
      ARID = '0; ARADDR = '0; ARLEN = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
      AWID = '0; AWADDR = '0; AWLEN = '0; AWBURST = '0; AWVALID = 1'b0;
      WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
      ARESETn = 1'b0;
      model_prio_wr = 1'b0;
      @(negedge ACLK);
      test_reset();
      test_single();
      test_incr_burst();
      test_contention();
      test_partial();
      test_wlast_err();
      test_wrap_len15();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule
